// File: rtl/avalon_stream_fifo.sv
// Show-ahead ready/valid FIFO buffering an Avalon stream ahead of the clock crosser.
// Latency: a word pushed in cycle N appears on out_valid/out_data in cycle N+1; no bypass when empty.
// Backpressure: in_ready drops when full and rises only the cycle after a pop; AVALON_STREAM_FIFO_LEVEL_EN adds level/almost_full.
module avalon_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop;

    // Flags come only from the registered count, so no input-to-output combinational path exists.
    assign in_ready  = (count != DEPTH_CNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage is deliberately left out of reset; words are written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef AVALON_STREAM_FIFO_LEVEL_EN
    assign level       = count;
    assign almost_full = (count >= (DEPTH_CNT - CNT_ONE));
`endif

endmodule

// File: tb/tb_avalon_stream_fifo.sv
// Directed self-checking bench for avalon_stream_fifo at DATA_WIDTH=8, DEPTH=4.
module tb_avalon_stream_fifo;

    logic       clk;
    logic       reset;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
    logic [2:0] level;
    logic       almost_full;
`endif

    int total;
    int bad;

    avalon_stream_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_ready  (in_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
        total++;
        if (level !== 3'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_level got=%0d/%b want=0/0", level, almost_full);
        end
`endif
        #10;
        reset = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [7:0] wr_words [4];
        logic [7:0] rd_words [5];
        wr_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        rd_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = wr_words[i];
            step();
        end
        in_data = 8'h55;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full_in_ready got=%b want=0", in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b0 || out_data !== 8'h11) begin
            bad++;
            $display("FAIL fill_held got=%b/%h want=0/11", in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i <= 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== rd_words[i]) begin
                bad++;
                $display("FAIL fill_drain_%0d got=%b/%h want=1/%h", i, out_valid, out_data, rd_words[i]);
            end
            if (i == 0) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_pop_no_push got=%b want=0", in_ready);
                end
            end
            if (i == 1) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_ready_after_pop got=%b want=1", in_ready);
                end
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL fill_empty got=%b/%b want=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_cycle_n got=%b want=0", out_valid);
        end
        step();
        in_valid = 1'b0;
        in_data  = 'x;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL latency_cycle_n1 got=%b/%h want=1/a5", out_valid, out_data);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL latency_hold_x got=%b/%h want=1/a5", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_data   = 8'h00;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_pop got=%b want=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_words [8];
        exp_words = '{8'hB0, 8'hB1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        step();
        in_data = 8'hB1;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 6);
            in_data  = 8'(i + 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
                bad++;
                $display("FAIL b2b_word_%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp_words[i]);
            end
            if (i < 6) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_%0d got=%b want=1", i, in_ready);
                end
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
                total++;
                if (level !== 3'd2) begin
                    bad++;
                    $display("FAIL b2b_level_%0d got=%0d want=2", i, level);
                end
`endif
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty got=%b want=0", out_valid);
        end
    endtask

    task automatic test_wrap();
        int sent;
        int rcvd;
        int mcnt;
        logic push_m;
        logic pop_m;
        sent = 0;
        rcvd = 0;
        mcnt = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_data   = 8'(sent);
            out_ready = cyc[0];
            total++;
            if (in_ready !== (mcnt != 4) || out_valid !== (mcnt != 0)) begin
                bad++;
                $display("FAIL wrap_flags_%0d got=%b/%b cnt=%0d", cyc, in_ready, out_valid, mcnt);
            end
            push_m = in_valid && (mcnt != 4);
            pop_m  = out_ready && (mcnt != 0);
            if (pop_m) begin
                total++;
                if (out_data !== 8'(rcvd)) begin
                    bad++;
                    $display("FAIL wrap_data got=%h want=%h", out_data, 8'(rcvd));
                end
                rcvd++;
            end
            if (push_m) sent++;
            mcnt = mcnt + int'(push_m) - int'(pop_m);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (rcvd != 10 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_complete got=%0d/%b want=10/0", rcvd, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC1 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_async got=%b/%b want=0/1", out_valid, in_ready);
        end
        step();
        #3;
        reset = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            bad++;
            $display("FAIL reset_mid_first got=%b/%h want=1/77", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_drain got=%b want=0", out_valid);
        end
    endtask

`ifdef AVALON_STREAM_FIFO_LEVEL_EN
    task automatic test_level();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hD0 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (level !== 3'd3 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL level_three got=%0d/%b want=3/1", level, almost_full);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (level !== 3'd2 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL level_two got=%0d/%b want=2/0", level, almost_full);
        end
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_latency();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef AVALON_STREAM_FIFO_LEVEL_EN
        test_level();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
